// File: rtl/asym_fifo_ctrl_n2w.sv
// asym_fifo_ctrl_n2w
//   Single-clock narrow-to-wide FIFO controller with an internal asymmetric RAM.
//   Narrow WIDTHB-bit words enter on a valid/ready write port. They are packed
//   lsb-first into WIDTHA-bit words that leave on a valid/ready read port.
//   The read stage is registered.
// Ports
//   clk          single clock, posedge
//   rst          synchronous active-high reset
//   flush        synchronous clear of contents, pointers and error flag
//   wr_valid     write request        wr_ready  write accepted when both high
//   wr_data      narrow write data
//   rd_valid     rd_data holds a wide word
//   rd_ready     consumer pop when rd_valid && rd_ready
//   rd_data      wide read data (registered)
//   count_b      narrow words held, including the word in the output register
//   full/empty   count_b == SIZEB / count_b == 0
//   err_wr_full  sticky: write attempted while full
module asym_fifo_ctrl_n2w #(
  parameter int WIDTHB     = 4,
  parameter int WIDTHA     = 16,
  parameter int SIZEB      = 1024,
  parameter int ADDRWIDTHB = 10,
  parameter int ADDRWIDTHA = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTHB-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTHA-1:0]     rd_data,
  output logic [ADDRWIDTHB:0]   count_b,
  output logic                  full,
  output logic                  empty,
  output logic                  err_wr_full
);

  localparam int RATIO = WIDTHA / WIDTHB;
  localparam int LOGR  = $clog2(RATIO);
  localparam logic [ADDRWIDTHB:0] RATIO_W = (ADDRWIDTHB + 1)'(RATIO);
  localparam logic [ADDRWIDTHB:0] SIZE_W  = (ADDRWIDTHB + 1)'(SIZEB);

  typedef enum logic {IDLE, VALID} rdState_t;

  rdState_t                state;
  rdState_t                stateNext;
  logic [WIDTHB-1:0]       mem [SIZEB];
  logic [ADDRWIDTHB-1:0]   wptr;
  logic [ADDRWIDTHA-1:0]   rptr;
  logic [ADDRWIDTHB:0]     avail;
  logic [ADDRWIDTHB:0]     countNext;
  logic [WIDTHA-1:0]       fetchWord;
  logic                    clear;
  logic                    wrAccept;
  logic                    pop;
  logic                    fetch;

  assign clear    = rst || flush;
  assign full     = (count_b == SIZE_W);
  assign empty    = (count_b == '0);
  assign wr_ready = !full && !rst && !flush;
  assign wrAccept = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready && !clear;

  // Words stored in RAM but not yet moved into the output register.
  assign avail = count_b - (rd_valid ? RATIO_W : '0);
  assign fetch = !clear && (avail >= RATIO_W) && (!rd_valid || pop);

  assign countNext = count_b + (wrAccept ? (ADDRWIDTHB + 1)'(1) : '0)
                             - (pop ? RATIO_W : '0);

  // Narrow write port; the RAM contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wptr] <= wr_data;
    end
  end

  // Wide read view: narrow word k of group rptr lands in slice k (lsb-first).
  always_comb begin
    fetchWord = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      fetchWord[k*WIDTHB +: WIDTHB] = mem[{rptr, LOGR'(k)}];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr        <= '0;
      rptr        <= '0;
      count_b     <= '0;
      rd_data     <= '0;
      err_wr_full <= 1'b0;
    end else begin
      if (wrAccept) begin
        wptr <= wptr + 1'b1;
      end
      if (fetch) begin
        rptr    <= rptr + 1'b1;
        rd_data <= fetchWord;
      end
      if (wr_valid && full) begin
        err_wr_full <= 1'b1;
      end
      count_b <= countNext;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (fetch)         stateNext = VALID;
      VALID:   if (pop && !fetch) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    rd_valid = (state == VALID);
  end

endmodule

// File: tb/tb_asym_fifo_ctrl_n2w.sv
module tb_asym_fifo_ctrl_n2w;

  localparam int WB = 4;
  localparam int WA = 16;
  localparam int SZ = 1024;
  localparam int R  = WA / WB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WB-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [WA-1:0] rd_data;
  logic [10:0]   count_b;
  logic          full;
  logic          empty;
  logic          err_wr_full;

  asym_fifo_ctrl_n2w #(
    .WIDTHB(WB), .WIDTHA(WA), .SIZEB(SZ), .ADDRWIDTHB(10), .ADDRWIDTHA(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count_b(count_b), .full(full), .empty(empty), .err_wr_full(err_wr_full)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of narrow words not yet moved to the output, plus the output word.
  logic [WB-1:0] mq[$];
  bit            mrv  = 1'b0;
  logic [WA-1:0] mrd  = '0;
  bit            merr = 1'b0;

  function automatic int mcount();
    return mq.size() + (mrv ? R : 0);
  endfunction

  always @(posedge clk) begin : model
    bit mpop, mfetch, mwr;
    if (rst || flush) begin
      mq.delete();
      mrv  = 1'b0;
      mrd  = '0;
      merr = 1'b0;
    end else begin
      mpop   = mrv && rd_ready;
      mwr    = wr_valid && (mcount() != SZ);
      if (wr_valid && mcount() == SZ) merr = 1'b1;
      mfetch = (mq.size() >= R) && (!mrv || mpop);
      if (mwr) mq.push_back(wr_data);
      if (mfetch) begin
        for (int k = 0; k < R; k++) mrd[k*WB +: WB] = mq.pop_front();
        mrv = 1'b1;
      end else if (mpop) begin
        mrv = 1'b0;
      end
    end
    checkEn = 1'b1;
  end

  always @(negedge clk) begin
    if (checkEn) begin
      chk("wr_ready", wr_ready, (mcount() != SZ) && !rst && !flush);
      chk("rd_valid", rd_valid, mrv);
      chk("count_b", count_b, mcount());
      chk("full", full, mcount() == SZ);
      chk("empty", empty, mcount() == 0);
      chk("err_wr_full", err_wr_full, merr);
      if (mrv) chk("rd_data", rd_data, mrd);
    end
  end

  // One clock: passes a posedge and returns just after the following negedge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // 1: reset
    repeat (3) cyc();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count_b, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_wr_ready", wr_ready, 1);

    // 2: one group, packing order and latency
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(i + 1);
      cyc();
    end
    wr_valid = 1'b0;
    chk("lat_not_yet", rd_valid, 0);
    cyc();
    chk("lat_valid", rd_valid, 1);
    chk("pack_4321", rd_data, 16'h4321);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    chk("pop_count", count_b, 0);
    chk("pop_empty", empty, 1);

    // 3: fill to full, overflow attempt, drain
    for (int i = 0; i < SZ; i++) begin
      wr_valid = 1'b1;
      wr_data  = i[3:0];
      cyc();
    end
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    wr_data = 4'hF;
    cyc();
    wr_valid = 1'b0;
    chk("ovf_err", err_wr_full, 1);
    chk("ovf_count", count_b, 1024);
    chk("drain_first", rd_data, 16'h3210);
    rd_ready = 1'b1;
    for (int j = 0; j < 128; j++) cyc();
    chk("drain_half", count_b, 512);
    for (int j = 0; j < 128; j++) cyc();
    chk("drain_done", count_b, 0);
    chk("drain_empty", empty, 1);

    // 4: continuous streaming, pointers wrap
    for (int j = 0; j < 3000; j++) begin
      wr_valid = 1'b1;
      wr_data  = 4'($urandom);
      cyc();
      if (count_b >= 11'(3 * R)) chk("stream_bound", count_b, 11'(3 * R - 1));
    end
    wr_valid = 1'b0;
    repeat (4) cyc();
    rd_ready = 1'b0;

    // 5: flush discards a partial group and clears the error flag
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'($urandom);
      cyc();
    end
    wr_valid = 1'b0;
    chk("pre_flush_err", err_wr_full, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_err", err_wr_full, 0);
    chk("flush_count", count_b, 0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(10 + i);
      cyc();
    end
    wr_valid = 1'b0;
    cyc();
    chk("flush_word", rd_data, 16'hDCBA);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    chk("flush_single", rd_valid, 0);

    // 6: stall stability, then mid-stream reset
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(5 + i);
      cyc();
    end
    for (int j = 0; j < 10; j++) begin
      wr_data = 4'($urandom);
      cyc();
      chk("stall_stable", rd_data, 16'h8765);
    end
    rst = 1'b1;
    cyc();
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_count", count_b, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    wr_valid = 1'b0;

    // Random traffic with occasional flush and reset
    for (int j = 0; j < 4000; j++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 4'($urandom);
      rd_ready = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 199) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    flush = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (300) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
